// File: rtl/gb_pkg.sv
// Shared Game Boy definitions: DMA FSM encoding, register/region constants
// and the echo-RAM source address fold.
package gb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  OAM_BASE_HI  = 8'hFE;
  localparam logic [7:0]  ECHO_LO      = 8'hE0;

  // Echo RAM (0xE000-0xFFFF) mirrors work RAM 0x2000 lower.
  function automatic logic [7:0] src_eff(input logic [7:0] hi);
    return (hi >= ECHO_LO) ? hi - 8'h20 : hi;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to 0xFF46 copies DMA_LEN bytes from
// {src_hi, 8'h00} into OAM at 0xFE00, one byte per machine cycle.
module oam_dma
  import gb_pkg::*;
#(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int DMA_LEN         = 160
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  di_cpu,
  input  logic        wr_n_cpu,
  input  logic        rd_n_cpu,
  output logic [7:0]  do_dma,
  output logic [15:0] src_addr,
  output logic        src_re,
  input  logic [7:0]  src_data,
  output logic [15:0] A_video,
  output logic [7:0]  di_video,
  output logic        wr_n_video,
  output logic        mem_enable_video,
  output logic        dma_active
);

  localparam logic [1:0] LAST_PHASE = 2'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);

  dma_state_t  state, state_nx;
  logic [1:0]  phase, phase_nx;
  logic [7:0]  idx, idx_nx;
  logic [7:0]  src_hi, src_hi_nx;
  logic [7:0]  byte_q, byte_nx;
  logic [15:0] src_addr_q, src_addr_nx;

  logic        cpu_wr;
  logic        xfer_rd;
  logic        xfer_wr;
  logic [15:0] rd_addr;

  assign cpu_wr  = !wr_n_cpu && (A_cpu == DMA_REG_ADDR);
  assign xfer_rd = (state == ST_XFER) && (phase < 2'd2);
  // A restart landing on phase 3 abandons the pending byte.
  assign xfer_wr = (state == ST_XFER) && (phase == LAST_PHASE) && !cpu_wr;
  assign rd_addr = {src_eff(src_hi), idx};

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_nx    = state;
    phase_nx    = phase;
    idx_nx      = idx;
    src_hi_nx   = src_hi;
    byte_nx     = byte_q;
    src_addr_nx = src_addr_q;

    if (xfer_rd) src_addr_nx = rd_addr;

    if (cpu_wr) begin
      src_hi_nx = di_cpu;
      idx_nx    = 8'd0;
      phase_nx  = 2'd0;
      state_nx  = ST_SETUP;
    end else begin
      unique case (state)
        ST_IDLE: ;
        ST_SETUP: begin
          phase_nx = phase + 2'd1;
          if (phase == LAST_PHASE) state_nx = ST_XFER;
        end
        ST_XFER: begin
          if (phase == 2'd2) byte_nx = src_data;
          phase_nx = phase + 2'd1;
          if (phase == LAST_PHASE) begin
            if (idx == LAST_IDX) state_nx = ST_IDLE;
            else                 idx_nx   = idx + 8'd1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous and wins over any simultaneous CPU write.
    if (reset) begin
      state      <= ST_IDLE;
      phase      <= 2'd0;
      idx        <= 8'd0;
      src_hi     <= 8'h00;
      byte_q     <= 8'h00;
      src_addr_q <= 16'h0000;
    end else begin
      state      <= state_nx;
      phase      <= phase_nx;
      idx        <= idx_nx;
      src_hi     <= src_hi_nx;
      byte_q     <= byte_nx;
      src_addr_q <= src_addr_nx;
    end
  end

  assign do_dma           = (!rd_n_cpu && (A_cpu == DMA_REG_ADDR)) ? src_hi : 8'hFF;
  assign dma_active       = (state != ST_IDLE);
  assign src_re           = xfer_rd;
  assign src_addr         = xfer_rd ? rd_addr : src_addr_q;
  assign wr_n_video       = !xfer_wr;
  assign mem_enable_video = xfer_wr;
  assign A_video          = xfer_wr ? {OAM_BASE_HI, idx} : 16'h0000;
  assign di_video         = xfer_wr ? byte_q : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: full transfer, echo fold, restart, reset abort,
// register readback and reset/write priority.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A_cpu;
  logic [7:0]  di_cpu;
  logic        wr_n_cpu;
  logic        rd_n_cpu;
  logic [7:0]  do_dma;
  logic [15:0] src_addr;
  logic        src_re;
  logic [7:0]  src_data;
  logic [15:0] A_video;
  logic [7:0]  di_video;
  logic        wr_n_video;
  logic        mem_enable_video;
  logic        dma_active;

  oam_dma dut (
    .clock            (clk),
    .reset            (reset),
    .A_cpu            (A_cpu),
    .di_cpu           (di_cpu),
    .wr_n_cpu         (wr_n_cpu),
    .rd_n_cpu         (rd_n_cpu),
    .do_dma           (do_dma),
    .src_addr         (src_addr),
    .src_re           (src_re),
    .src_data         (src_data),
    .A_video          (A_video),
    .di_video         (di_video),
    .wr_n_video       (wr_n_video),
    .mem_enable_video (mem_enable_video),
    .dma_active       (dma_active)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int act_cnt;
  logic [15:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int          wq_cyc[$];
  logic [15:0] sa_q[$];

  always @(posedge clk) cyc++;

  // Source memory: byte = low address ^ 0x5A, one clock read latency.
  always @(posedge clk) if (src_re) src_data <= src_addr[7:0] ^ 8'h5A;

  always @(negedge clk) begin
    if (dma_active) act_cnt++;
    if (!wr_n_video) begin
      wq_addr.push_back(A_video);
      wq_data.push_back(di_video);
      wq_cyc.push_back(cyc);
    end
    if (src_re) sa_q.push_back(src_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    act_cnt = 0;
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    sa_q.delete();
  endtask

  // Drives one write clock; returns the cycle number of the sampling edge.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int c0);
    wr_n_cpu = 1'b0;
    A_cpu    = a;
    di_cpu   = d;
    tick();
    c0       = cyc;
    wr_n_cpu = 1'b1;
    A_cpu    = 16'h0000;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && dma_active; i++) tick();
    check("idle_timeout", 32'(dma_active), 32'd0);
  endtask

  task automatic read_reg(input logic [15:0] a, output logic [7:0] d);
    rd_n_cpu = 1'b0;
    A_cpu    = a;
    #1;
    d        = do_dma;
    rd_n_cpu = 1'b1;
    A_cpu    = 16'h0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_active"}, 32'(dma_active), 32'd0);
    check({tag, "_src_re"}, 32'(src_re), 32'd0);
    check({tag, "_src_addr"}, 32'(src_addr), 32'h0000);
    check({tag, "_wr_n_video"}, 32'(wr_n_video), 32'd1);
    check({tag, "_mem_en"}, 32'(mem_enable_video), 32'd0);
    check({tag, "_A_video"}, 32'(A_video), 32'h0000);
    check({tag, "_di_video"}, 32'(di_video), 32'h00);
  endtask

  initial begin
    int c0, c1, bad;
    logic [7:0] rd;

    reset    = 1'b1;
    wr_n_cpu = 1'b1;
    rd_n_cpu = 1'b1;
    A_cpu    = 16'h0000;
    di_cpu   = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("reset");
    read_reg(16'hFF46, rd);
    check("reset_src_hi", 32'(rd), 32'h00);

    // Full transfer from 0xC100.
    clear_logs();
    cpu_write(16'hFF46, 8'hC1, c0);
    wait_idle();
    check("t1_count", wq_addr.size(), 160);
    check("t1_first_cyc", wq_cyc[0], c0 + 7);
    check("t1_active", act_cnt, 644);
    bad = 0;
    for (int i = 0; i < wq_addr.size() && i < 160; i++) begin
      if (wq_addr[i] !== 16'hFE00 + 16'(i)) bad++;
      if (wq_data[i] !== (8'(i) ^ 8'h5A)) bad++;
      if (wq_cyc[i] !== c0 + 7 + 4 * i) bad++;
    end
    check("t1_write_errors", bad, 0);
    check("t1_src_reads", sa_q.size(), 320);
    bad = 0;
    for (int i = 0; i < sa_q.size() && i < 320; i++)
      if (sa_q[i] !== 16'hC100 + 16'(i / 2)) bad++;
    check("t1_src_addr_errors", bad, 0);
    check("t1_src_addr_hold", 32'(src_addr), 32'hC19F);

    // Echo RAM source folds 0xE2 down to 0xC2.
    clear_logs();
    cpu_write(16'hFF46, 8'hE2, c0);
    wait_idle();
    check("t2_src_reads", sa_q.size(), 320);
    check("t2_src_first", 32'(sa_q[0]), 32'hC200);
    check("t2_src_last", 32'(sa_q[319]), 32'hC29F);

    // Restart at byte 50 phase 3.
    clear_logs();
    cpu_write(16'hFF46, 8'h80, c0);
    while (cyc < c0 + 207) tick();
    check("t3_ph3_pending", 32'(wr_n_video), 32'd0);
    cpu_write(16'hFF46, 8'h90, c1);
    wait_idle();
    check("t3_count", wq_addr.size(), 210);
    check("t3_last_before", 32'(wq_addr[49]), 32'hFE31);
    check("t3_first_after", 32'(wq_addr[50]), 32'hFE00);
    check("t3_first_after_cyc", wq_cyc[50], c1 + 7);
    check("t3_last_after", 32'(wq_addr[209]), 32'hFE9F);
    check("t3_active", act_cnt, 852);
    check("t3_src_restart", 32'(sa_q[102]), 32'h9000);
    bad = 0;
    for (int i = 0; i < wq_addr.size(); i++)
      if (wq_addr[i] === 16'hFE32 && i < 50) bad++;
    check("t3_no_fe32", bad, 0);

    // Reset at byte 10 phase 1.
    clear_logs();
    cpu_write(16'hFF46, 8'h80, c0);
    while (cyc < c0 + 45) tick();
    check("t4_src_re_ph1", 32'(src_re), 32'd1);
    reset = 1'b1;
    tick();
    check_reset_outputs("t4");
    reset = 1'b0;
    repeat (20) tick();
    check("t4_writes", wq_addr.size(), 10);
    check("t4_still_idle", 32'(dma_active), 32'd0);

    // Register readback and decode.
    cpu_write(16'hFF46, 8'h3C, c0);
    read_reg(16'hFF46, rd);
    check("t5_read_ff46", 32'(rd), 32'h3C);
    read_reg(16'hFF45, rd);
    check("t5_read_ff45", 32'(rd), 32'hFF);
    check("t5_no_read", 32'(do_dma), 32'hFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_logs();
    cpu_write(16'hFF47, 8'h55, c0);
    repeat (10) tick();
    check("t5_ff47_active", act_cnt, 0);
    read_reg(16'hFF46, rd);
    check("t5_ff47_src_hi", 32'(rd), 32'h00);

    // Reset beats a simultaneous write.
    clear_logs();
    reset = 1'b1;
    cpu_write(16'hFF46, 8'hC0, c0);
    reset = 1'b0;
    check("t6_active", 32'(dma_active), 32'd0);
    repeat (10) tick();
    check("t6_active_cnt", act_cnt, 0);
    read_reg(16'hFF46, rd);
    check("t6_src_hi", 32'(rd), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter CYCLES_PER_BYTE, default 4, clocks per transferred byte (one CPU machine cycle); fixed at 4, other values are unsupported.
REQ-002 Parameter DMA_LEN, default 160, bytes per transfer (OAM size).
REQ-003 Port: clock  in  1  single clock for all logic, rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: A_cpu  in  16  CPU address.
REQ-006 Port: di_cpu  in  8  CPU write data.
REQ-007 Port: wr_n_cpu  in  1  CPU write strobe, active-low, one clock per access.
REQ-008 Port: rd_n_cpu  in  1  CPU read strobe, active-low.
REQ-009 Port: do_dma  out  8  readback data for 0xFF46.
REQ-010 Port: src_addr  out  16  source bus address.
REQ-011 Port: src_re  out  1  source read enable, active-high.
REQ-012 Port: src_data  in  8  source read data, valid one clock after src_addr/src_re are sampled.
REQ-013 Port: A_video  out  16  address to gpu_top.
REQ-014 Port: di_video  out  8  write data to gpu_top.
REQ-015 Port: wr_n_video  out  1  write strobe to gpu_top, active-low.
REQ-016 Port: mem_enable_video  out  1  gpu_top bus enable, high during a video write.
REQ-017 Port: dma_active  out  1  high while a transfer is in progress; the arbiter restricts the CPU to HRAM.

Function
REQ-018 A CPU write is a clock with wr_n_cpu=0 and A_cpu=0xFF46; it latches di_cpu into src_hi.
REQ-019 While rd_n_cpu=0 and A_cpu=0xFF46, do_dma shall equal src_hi; otherwise do_dma shall be 0xFF.
REQ-020 FSM states: IDLE, SETUP, XFER.
REQ-021 IDLE to SETUP on a CPU write; idx is cleared to 0 and dma_active rises on the next clock.
REQ-022 SETUP lasts exactly CYCLES_PER_BYTE clocks with no bus activity, then goes to XFER at phase 0.
REQ-023 XFER uses a 2-bit phase counter, 0 to 3, per byte.
REQ-024 Phase 0: src_re=1 and src_addr={src_eff, idx}.
REQ-025 Phase 1: src_re=1, same address.
REQ-026 Phase 2: src_data is captured into a byte register.
REQ-027 Phase 3: wr_n_video=0, mem_enable_video=1, A_video={8'hFE, idx}, di_video=captured byte.
REQ-028 At phase 3, if idx=DMA_LEN-1, go to IDLE; otherwise idx increments and the next byte starts at phase 0.
REQ-029 src_eff = src_hi - 0x20 when src_hi is 0xE0 to 0xFF (echo RAM mapping); otherwise src_eff = src_hi.
REQ-030 idx is 8-bit, never exceeds DMA_LEN-1, and never wraps.
REQ-031 Total duration from the write clock to dma_active falling is 4 + 160*4 = 644 clocks.
REQ-032 A CPU write to 0xFF46 in SETUP or XFER restarts the transfer: src_hi is reloaded, idx=0, state goes to SETUP, and any byte not yet written is abandoned.
REQ-033 A restart coinciding with phase 3 suppresses that phase-3 write.
REQ-034 Outside XFER phase 3: wr_n_video=1, mem_enable_video=0, A_video=0x0000, di_video=0x00.
REQ-035 Outside XFER phases 0 and 1: src_re=0; src_addr holds its last value.
REQ-036 CPU writes to addresses other than 0xFF46 have no effect.

Reset
REQ-037 When reset is high at a clock edge: state=IDLE, idx=0, phase=0, src_hi=0x00, dma_active=0, src_re=0, src_addr=0x0000, wr_n_video=1, mem_enable_video=0, A_video=0x0000, di_video=0x00.
REQ-038 Reset mid-transfer aborts the transfer immediately with no further writes.
REQ-039 Reset has priority over a simultaneous CPU write.

Structure
REQ-040 A shared package (gb_pkg) holds the FSM state encoding and the constants DMA_REG_ADDR=16'hFF46, OAM_BASE_HI=8'hFE, ECHO_LO=8'hE0.
REQ-041 The block is a single module with no sub-modules.
REQ-042 A downstream top level connects A_video, di_video, wr_n_video and mem_enable_video to gpu_top through an arbiter that selects DMA when dma_active=1.

Verification
REQ-043 Write 0xC1 to 0xFF46 with a source model holding byte = low address ^ 0x5A -> 160 writes to 0xFE00 through 0xFE9F with matching data, one every 4 clocks, first write at clock 7 after the CPU write, dma_active high for 644 clocks.
REQ-044 Write 0xE2 -> src_addr runs 0xC200 through 0xC29F.
REQ-045 Write 0x80, then at byte 50 phase 3 write 0x90 -> no write to 0xFE32, restart from 0x9000, 160 writes total after the restart, dma_active continuous.
REQ-046 Assert reset at byte 10 phase 1 -> no further writes, all outputs at reset values on the next clock.
REQ-047 Write 0x3C, then read 0xFF46 -> do_dma=0x3C; read 0xFF45 -> do_dma=0xFF; write 0xFF47 -> no transfer starts.
REQ-048 Write 0xC0 and reset in the same clock -> stays in IDLE, src_hi=0x00.
